rv_instr_encoder: RTL and testbench
===================================

# rv_instr_encoder

Encodes a stream of decoded RV32I instruction descriptors into 32-bit machine words and writes them sequentially into instruction memory. It is the inverse of the core's control/decode path. It sits between the testbench/boot-loader front end and the instruction memory write port. A valid/ready input handshake, a one-entry output register with backpressure, an address counter and field-legality checks make it a self-contained program loader.

## Interface
- `ADDR_W`, 10, instruction-memory word-address width
- `BASE_ADDR`, 0, first word address written after `start`
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  pulse: begin/restart a load session
- `in_valid` / `in_ready`  in/out  1  descriptor handshake
- `in_op`  in  4  `enc_op_t`: ADD, SUB, ADDI, LW, SW, BEQ, JAL, JALR, LUI, AUIPC (codes 0–9)
- `in_rd`, `in_rs1`, `in_rs2`  in  5  register indices (unused fields ignored)
- `in_imm`  in  32  signed byte offset/immediate; for LUI/AUIPC the full 32-bit value
- `in_last`  in  1  marks final descriptor of the session
- `mem_wr_en`  out  1  write request, held until accepted
- `mem_wr_ready`  in  1  memory accepts write this cycle
- `mem_wr_addr`  out  ADDR_W  word address
- `mem_wr_data`  out  32  encoded instruction
- `busy`  out  1  state is RUN or FLUSH
- `done`  out  1  one-cycle pulse at session completion
- `err`  out  1  sticky error flag
- `err_code`  out  2  01 illegal op, 10 immediate range/alignment, 11 address overflow
- `instr_count`  out  ADDR_W+1  words written this session

## Operation
- FSM states:
  - IDLE: `in_ready`=0.
  - RUN: accepting descriptors.
  - FLUSH: `in_last` accepted, waiting for the output register to drain.
  - ERR: halted.
- Transitions:
  - `start` from any state → RUN. This clears the output register (any pending write is dropped), `err`, `err_code` and `instr_count`, and loads the next address with `BASE_ADDR`.
  - RUN → FLUSH on acceptance of a descriptor with `in_last`=1.
  - FLUSH → IDLE when the final write completes; `done`=1 in that cycle.
  - RUN → ERR on a rejected descriptor.
- `in_ready` = (state==RUN) && (!out_valid || `mem_wr_ready`).
- Acceptance (`in_valid` && `in_ready`): the descriptor is checked and encoded combinationally, then loaded into the output register with the next address. The next address then increments.
- Encoding uses the standard RV32I formats:
  - R-type (funct7 0000000 for ADD, 0100000 for SUB).
  - I-type: ADDI and JALR use f3=000; LW uses f3=010.
  - S-type: SW, f3=010.
  - B-type: BEQ, f3=000.
  - J-type: JAL.
  - U-type: LUI and AUIPC, taking `in_imm[31:12]`.
- Illegal op (>9): error 01.
- Immediate checks:
  - I/S: −2048..2047.
  - B: −4096..4094 and even.
  - J: −2^20..2^20−2 and even.
  - U: `in_imm[11:0]`==0.
  - Any failure gives error 10.
- Address overflow: the next address reaching BASE_ADDR+2^ADDR_W (tracked at ADDR_W+1 bits) gives error 11.
- On error: the descriptor is not written and the state goes to ERR. A write already pending still completes and still counts. `err` holds until `start`.
- `instr_count` increments on each cycle with `mem_wr_en` && `mem_wr_ready`.

## Timing
- Reset values: state IDLE; `in_ready`, `mem_wr_en`, `done`, `err` = 0; `err_code` = 0; `mem_wr_data` = 0; `instr_count` = 0; `mem_wr_addr` = BASE_ADDR.
- Latency: one cycle from acceptance to `mem_wr_en`=1.
- Throughput: one word per cycle when `mem_wr_ready` is held high. Drain and new accept may occur in the same cycle.
- While `mem_wr_en`=1 and `mem_wr_ready`=0, `mem_wr_addr` and `mem_wr_data` are stable.
- `start` has priority over `in_valid` in the same cycle. No descriptor is accepted in the `start` cycle.
- `rst_n` deasserted mid-session aborts immediately. Outputs return to reset values with no further writes.
- `in_last` on a descriptor that errors: the state goes to ERR and no `done` pulse occurs.

## Configuration
- `RV_ENC_RANGE_CHECK_EN` defined: immediate range/alignment checks active; error 10 is possible.
- `RV_ENC_RANGE_CHECK_EN` undefined: immediates are silently truncated to field width and the LSB is dropped for B/J. Error 10 is never raised. Op and overflow checks remain.

## Structure
- Shared `RISC_ISA_pkg` gains:
  - the `enc_op_t` enum;
  - the `OP_JAL`, `OP_JALR`, `OP_LUI` and `OP_AUIPC` opcode constants;
  - the `FUNCT3_*` constants;
  - the `ENC_ERR_*` codes.
- Existing `OP_*` and `FUNCT7_SUB` constants are reused.
- One sub-module, `rv_instr_pack`: purely combinational descriptor → {word, illegal, range_err}. The FSM, output register and counters stay in the top.

## Test plan
- `start`, ADDI x1,x0,5 → write 0x00500093 at addr 0, one cycle after accept.
- ADD x3,x1,x2 then SUB x3,x1,x2 back-to-back with `mem_wr_ready`=1 → 0x002081B3 @0, 0x402081B3 @1 on consecutive cycles.
- LW x5,8(x2); SW x5,12(x2); BEQ x1,x2,−8 (last), with `mem_wr_ready` low for 3 cycles on the second write:
  - data/addr stable during the stall;
  - words 0x00812283, 0x00512623, 0xFE208CE3 written;
  - `done` pulses; `instr_count`=3.
- LUI x1,0x12345000 → 0x123450B7. JAL x1,2048 → 0x001000EF.
- ADDI with imm 4096 (range check enabled) → `err`=1, `err_code`=10, no write, `in_ready`=0. Then `start` → `err` cleared, addr 0.
- `ADDR_W`=2: five accepted descriptors → four writes, fifth rejected with `err_code`=11. `start` mid-stall drops the pending write.

Source files
------------

// File: rtl/RISC_ISA_pkg.sv
// Shared RV32I constants plus the descriptor encoder's op enum, FSM states and error codes.
// fits_signed() backs the optional immediate checks enabled by RV_ENC_RANGE_CHECK_EN.
package RISC_ISA_pkg;

   localparam logic [6:0] OP_R_TYPE = 7'b0110011;
   localparam logic [6:0] OP_I_TYPE = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [6:0] FUNCT7_ADD = 7'b0000000;
   localparam logic [6:0] FUNCT7_SUB = 7'b0100000;

   localparam logic [2:0] FUNCT3_ADD  = 3'b000;
   localparam logic [2:0] FUNCT3_LW   = 3'b010;
   localparam logic [2:0] FUNCT3_SW   = 3'b010;
   localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
   localparam logic [2:0] FUNCT3_JALR = 3'b000;

   localparam logic [1:0] ENC_ERR_NONE     = 2'b00;
   localparam logic [1:0] ENC_ERR_ILLEGAL  = 2'b01;
   localparam logic [1:0] ENC_ERR_RANGE    = 2'b10;
   localparam logic [1:0] ENC_ERR_OVERFLOW = 2'b11;

   typedef enum logic [3:0] {
      ENC_ADD   = 4'd0,
      ENC_SUB   = 4'd1,
      ENC_ADDI  = 4'd2,
      ENC_LW    = 4'd3,
      ENC_SW    = 4'd4,
      ENC_BEQ   = 4'd5,
      ENC_JAL   = 4'd6,
      ENC_JALR  = 4'd7,
      ENC_LUI   = 4'd8,
      ENC_AUIPC = 4'd9
   } enc_op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_ERR   = 2'd3
   } enc_state_t;

   // True when v survives truncation to a width-bit two's-complement field.
   function automatic logic fits_signed(input logic [31:0] v, input int unsigned width);
      logic [31:0] hi;
      hi = 32'($signed(v) >>> (width - 1));
      return (hi == '0) || (hi == '1);
   endfunction

endpackage

// File: rtl/rv_instr_pack.sv
// Combinational descriptor-to-word packer for the RV32I subset handled by the loader.
// With RV_ENC_RANGE_CHECK_EN defined it also flags out-of-range or misaligned immediates.
module rv_instr_pack
   import RISC_ISA_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        illegal,
   output logic        range_err
);

   always_comb begin
      // NOTE: every output is defaulted first so no path through the case infers a latch.
      word      = '0;
      illegal   = 1'b0;
      range_err = 1'b0;
      case (op)
         ENC_ADD:   word = {FUNCT7_ADD, rs2, rs1, FUNCT3_ADD, rd, OP_R_TYPE};
         ENC_SUB:   word = {FUNCT7_SUB, rs2, rs1, FUNCT3_ADD, rd, OP_R_TYPE};
         ENC_ADDI:  word = {imm[11:0], rs1, FUNCT3_ADD, rd, OP_I_TYPE};
         ENC_LW:    word = {imm[11:0], rs1, FUNCT3_LW, rd, OP_LOAD};
         ENC_SW:    word = {imm[11:5], rs2, rs1, FUNCT3_SW, imm[4:0], OP_STORE};
         ENC_BEQ:   word = {imm[12], imm[10:5], rs2, rs1, FUNCT3_BEQ, imm[4:1], imm[11], OP_BRANCH};
         ENC_JAL:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
         ENC_JALR:  word = {imm[11:0], rs1, FUNCT3_JALR, rd, OP_JALR};
         ENC_LUI:   word = {imm[31:12], rd, OP_LUI};
         ENC_AUIPC: word = {imm[31:12], rd, OP_AUIPC};
         default:   illegal = 1'b1;
      endcase
`ifdef RV_ENC_RANGE_CHECK_EN
      case (op)
         ENC_ADDI, ENC_LW, ENC_SW, ENC_JALR: range_err = !fits_signed(imm, 12);
         ENC_BEQ:                            range_err = !fits_signed(imm, 13) || imm[0];
         ENC_JAL:                            range_err = !fits_signed(imm, 21) || imm[0];
         ENC_LUI, ENC_AUIPC:                 range_err = (imm[11:0] != 12'd0);
         default:                            range_err = 1'b0;
      endcase
`endif
   end

endmodule

// File: rtl/rv_instr_encoder.sv
// Program loader: accepts decoded RV32I descriptors, encodes them and writes them to
// sequential instruction-memory words. Immediate checks are compiled in by RV_ENC_RANGE_CHECK_EN.
module rv_instr_encoder
   import RISC_ISA_pkg::*;
#(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned BASE_ADDR = 0
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [31:0]       in_imm,
   input  logic              in_last,
   output logic              mem_wr_en,
   input  logic              mem_wr_ready,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [31:0]       mem_wr_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [ADDR_W:0]   instr_count
);

   localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

   enc_state_t      state;
   logic            out_valid;
   logic [ADDR_W:0] next_off;
   logic [31:0]     pack_word;
   logic            illegal;
   logic            range_err;
   logic            drain;
   logic [1:0]      fault_code;

   rv_instr_pack u_pack (
      .op        (in_op),
      .rd        (in_rd),
      .rs1       (in_rs1),
      .rs2       (in_rs2),
      .imm       (in_imm),
      .word      (pack_word),
      .illegal   (illegal),
      .range_err (range_err)
   );

   assign drain     = out_valid && mem_wr_ready;
   assign in_ready  = (state == ST_RUN) && (!out_valid || mem_wr_ready);
   assign mem_wr_en = out_valid;
   assign busy      = (state == ST_RUN) || (state == ST_FLUSH);
   assign done      = (state == ST_FLUSH) && drain;

   // The extra offset bit set means the window of 2^ADDR_W words is used up.
   always_comb begin
      fault_code = ENC_ERR_NONE;
      if (illegal)                fault_code = ENC_ERR_ILLEGAL;
      else if (range_err)         fault_code = ENC_ERR_RANGE;
      else if (next_off[ADDR_W])  fault_code = ENC_ERR_OVERFLOW;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         state       <= ST_IDLE;
         out_valid   <= 1'b0;
         mem_wr_addr <= ADDR_BASE;
         mem_wr_data <= '0;
         next_off    <= '0;
         err         <= 1'b0;
         err_code    <= ENC_ERR_NONE;
         instr_count <= '0;
      end else if (start) begin
         state       <= ST_RUN;
         out_valid   <= 1'b0;
         mem_wr_addr <= ADDR_BASE;
         mem_wr_data <= '0;
         next_off    <= '0;
         err         <= 1'b0;
         err_code    <= ENC_ERR_NONE;
         instr_count <= '0;
      end else begin
         // A pending write drains in any state, including ERR.
         if (drain) begin
            out_valid   <= 1'b0;
            instr_count <= instr_count + CNT_ONE;
         end
         case (state)
            ST_RUN: begin
               if (in_valid && in_ready) begin
                  if (fault_code != ENC_ERR_NONE) begin
                     state    <= ST_ERR;
                     err      <= 1'b1;
                     err_code <= fault_code;
                  end else begin
                     out_valid   <= 1'b1;
                     mem_wr_data <= pack_word;
                     mem_wr_addr <= ADDR_BASE + next_off[ADDR_W-1:0];
                     next_off    <= next_off + CNT_ONE;
                     if (in_last) state <= ST_FLUSH;
                  end
               end
            end
            ST_FLUSH: if (drain) state <= ST_IDLE;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Self-checking bench for rv_instr_encoder: directed test-plan steps plus a randomized session
// scored against a table-driven encoding model; follows RV_ENC_RANGE_CHECK_EN when defined.
module tb_rv_instr_encoder;

   localparam int AW  = 10;
   localparam int AW2 = 2;

   logic clk = 1'b0;
   logic rst_n, start, in_valid, in_last, mem_wr_ready;
   logic [3:0]  in_op;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [31:0] in_imm;

   logic          in_ready, mem_wr_en, busy, done, err;
   logic [AW-1:0] mem_wr_addr;
   logic [31:0]   mem_wr_data;
   logic [1:0]    err_code;
   logic [AW:0]   instr_count;

   logic           in_ready2, mem_wr_en2, busy2, done2, err2;
   logic [AW2-1:0] mem_wr_addr2;
   logic [31:0]    mem_wr_data2;
   logic [1:0]     err_code2;
   logic [AW2:0]   instr_count2;

   rv_instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .in_last(in_last), .mem_wr_en(mem_wr_en), .mem_wr_ready(mem_wr_ready),
      .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .busy(busy), .done(done),
      .err(err), .err_code(err_code), .instr_count(instr_count));

   rv_instr_encoder #(.ADDR_W(AW2), .BASE_ADDR(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
      .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .in_last(in_last), .mem_wr_en(mem_wr_en2), .mem_wr_ready(mem_wr_ready),
      .mem_wr_addr(mem_wr_addr2), .mem_wr_data(mem_wr_data2), .busy(busy2), .done(done2),
      .err(err2), .err_code(err_code2), .instr_count(instr_count2));

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   wr_t wr_q[$];
   int  dut2_writes = 0;
   int  n_checks = 0;
   int  n_fail = 0;
   bit  rnd_ready = 1'b0;

   // Write monitor: a memory write happens on each rising edge with en && ready.
   always @(posedge clk) begin
      if (rst_n && mem_wr_en && mem_wr_ready) wr_q.push_back('{mem_wr_addr, mem_wr_data});
      if (rst_n && mem_wr_en2 && mem_wr_ready) dut2_writes++;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
      return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
   endfunction

   // Reference encoder: per-op tables for opcode/funct3 and the format rules of RV32I.
   function automatic void ref_encode(input int op, input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [31:0] imm,
                                      output logic [31:0] word, output logic [1:0] code);
      logic [31:0] opc [10] = '{32'h33, 32'h33, 32'h13, 32'h03, 32'h23,
                                32'h63, 32'h6F, 32'h67, 32'h37, 32'h17};
      logic [31:0] f3  [10] = '{0, 0, 0, 2, 2, 0, 0, 0, 0, 0};
      logic [31:0] regs;
      int s;
      word = '0;
      code = 2'd0;
      if (op > 9) begin
         code = 2'd1;
         return;
      end
      s = $signed(imm);
      regs = (32'(rs2) << 20) | (32'(rs1) << 15) | (f3[op] << 12);
      case (op)
         0, 1:    word = ((op == 1) ? (32'd32 << 25) : 32'd0) | regs | (32'(rd) << 7) | opc[op];
         2, 3, 7: word = (fld(imm, 11, 0) << 20) | (32'(rs1) << 15) | (f3[op] << 12) | (32'(rd) << 7) | opc[op];
         4:       word = (fld(imm, 11, 5) << 25) | regs | (fld(imm, 4, 0) << 7) | opc[op];
         5:       word = (fld(imm, 12, 12) << 31) | (fld(imm, 10, 5) << 25) | regs
                         | (fld(imm, 4, 1) << 8) | (fld(imm, 11, 11) << 7) | opc[op];
         6:       word = (fld(imm, 20, 20) << 31) | (fld(imm, 10, 1) << 21) | (fld(imm, 11, 11) << 20)
                         | (fld(imm, 19, 12) << 12) | (32'(rd) << 7) | opc[op];
         default: word = (imm & 32'hFFFFF000) | (32'(rd) << 7) | opc[op];
      endcase
`ifdef RV_ENC_RANGE_CHECK_EN
      begin
         bit bad;
         case (op)
            2, 3, 4, 7: bad = (s < -2048) || (s > 2047);
            5:          bad = (s < -4096) || (s > 4094) || ((s & 1) != 0);
            6:          bad = (s < -(1 << 20)) || (s > (1 << 20) - 2) || ((s & 1) != 0);
            8, 9:       bad = (imm % 4096) != 0;
            default:    bad = 1'b0;
         endcase
         if (bad) begin
            code = 2'd2;
            word = '0;
         end
      end
`else
      if (s == 0) word = word;
`endif
   endfunction

   task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm, input logic last);
      int waited = 0;
      in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
      in_valid = 1'b1;
      forever begin
         if (rnd_ready) mem_wr_ready = ($urandom_range(0, 9) < 7);
         #1;
         if (in_ready) break;
         waited++;
         if (waited > 50) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic do_start();
      in_valid = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Sends one descriptor and checks either its write or the error it should raise.
   task automatic send_expect(input string tag, input int op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm, input logic last, input int addr);
      logic [31:0] w;
      logic [1:0]  c;
      ref_encode(op, rd, rs1, rs2, imm, w, c);
      send(4'(op), rd, rs1, rs2, imm, last);
      #1;
      if (c == 2'd0) begin
         check({tag, "_en"}, 64'(mem_wr_en), 64'd1);
         check({tag, "_data"}, 64'(mem_wr_data), 64'(w));
         check({tag, "_addr"}, 64'(mem_wr_addr), 64'(addr));
      end else begin
         check({tag, "_err"}, 64'(err), 64'd1);
         check({tag, "_code"}, 64'(err_code), 64'(c));
         check({tag, "_no_done"}, 64'(done), 64'd0);
      end
   endtask

   initial begin
      int base;
      int base2;
      logic [31:0] w;
      logic [1:0]  c;
      wr_t exp_q[$];

      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; mem_wr_ready = 1'b1;
      in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_wr_en", 64'(mem_wr_en), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_err_code", 64'(err_code), 64'd0);
      check("rst_data", 64'(mem_wr_data), 64'd0);
      check("rst_count", 64'(instr_count), 64'd0);
      check("rst_addr", 64'(mem_wr_addr), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // ADDI x1,x0,5 appears on the write port one cycle after acceptance.
      do_start();
      send(4'd2, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
      check("addi_en", 64'(mem_wr_en), 64'd1);
      check("addi_data", 64'(mem_wr_data), 64'h00500093);
      check("addi_addr", 64'(mem_wr_addr), 64'd0);

      // ADD then SUB back-to-back.
      do_start();
      send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
      check("add_data", 64'(mem_wr_data), 64'h002081B3);
      check("add_addr", 64'(mem_wr_addr), 64'd0);
      send(4'd1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
      check("sub_data", 64'(mem_wr_data), 64'h402081B3);
      check("sub_addr", 64'(mem_wr_addr), 64'd1);

      // LW / SW (stalled 3 cycles) / BEQ last, then done and count.
      do_start();
      base = wr_q.size();
      send(4'd3, 5'd5, 5'd2, 5'd0, 32'd8, 1'b0);
      send(4'd4, 5'd0, 5'd2, 5'd5, 32'd12, 1'b0);
      mem_wr_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_en", 64'(mem_wr_en), 64'd1);
         check("stall_data", 64'(mem_wr_data), 64'h00512623);
         check("stall_addr", 64'(mem_wr_addr), 64'd1);
         check("stall_in_ready", 64'(in_ready), 64'd0);
         @(negedge clk);
      end
      mem_wr_ready = 1'b1;
      send(4'd5, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b1);
      #1;
      check("beq_data", 64'(mem_wr_data), 64'hFE208CE3);
      check("beq_addr", 64'(mem_wr_addr), 64'd2);
      check("flush_done", 64'(done), 64'd1);
      check("flush_busy", 64'(busy), 64'd1);
      @(negedge clk);
      #1;
      check("post_done", 64'(done), 64'd0);
      check("post_busy", 64'(busy), 64'd0);
      check("post_count", 64'(instr_count), 64'd3);
      check("seq_nwrites", 64'(wr_q.size() - base), 64'd3);
      if (wr_q.size() - base == 3) begin
         check("seq_w0", 64'(wr_q[base].data), 64'h00812283);
         check("seq_w1", 64'(wr_q[base + 1].data), 64'h00512623);
         check("seq_w2", 64'(wr_q[base + 2].data), 64'hFE208CE3);
         check("seq_a2", 64'(wr_q[base + 2].addr), 64'd2);
      end

      // LUI and JAL.
      do_start();
      send(4'd8, 5'd1, 5'd0, 5'd0, 32'h12345000, 1'b0);
      check("lui_data", 64'(mem_wr_data), 64'h123450B7);
      send(4'd6, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
      check("jal_data", 64'(mem_wr_data), 64'h001000EF);
      check("jal_addr", 64'(mem_wr_addr), 64'd1);

      // ADDI imm 4096: range error when checks are compiled in, truncated otherwise.
      do_start();
      base = wr_q.size();
      send_expect("addi4096", 2, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b0, 0);
      ref_encode(2, 5'd1, 5'd0, 5'd0, 32'd4096, w, c);
      repeat (2) @(negedge clk);
      #1;
      check("addi4096_in_ready", 64'(in_ready), (c == 2'd0) ? 64'd1 : 64'd0);
      check("addi4096_nwrites", 64'(wr_q.size() - base), (c == 2'd0) ? 64'd1 : 64'd0);
      do_start();
      #1;
      check("restart_err", 64'(err), 64'd0);
      check("restart_code", 64'(err_code), 64'd0);
      check("restart_addr", 64'(mem_wr_addr), 64'd0);

      // Illegal op right behind a good write: pending write still completes and counts.
      base = wr_q.size();
      send(4'd2, 5'd2, 5'd0, 5'd0, 32'd7, 1'b0);
      send(4'd12, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0);
      #1;
      check("illegal_err", 64'(err), 64'd1);
      check("illegal_code", 64'(err_code), 64'd1);
      check("illegal_wr_en", 64'(mem_wr_en), 64'd0);
      check("illegal_count", 64'(instr_count), 64'd1);
      check("illegal_busy", 64'(busy), 64'd0);
      check("illegal_nwrites", 64'(wr_q.size() - base), 64'd1);

      // Immediate boundaries, then an odd branch offset marked last.
      do_start();
      send_expect("addi_min", 2, 5'd4, 5'd6, 5'd0, -32'sd2048, 1'b0, 0);
      send_expect("sw_max", 4, 5'd0, 5'd6, 5'd7, 32'd2047, 1'b0, 1);
      send_expect("beq_max", 5, 5'd0, 5'd1, 5'd2, 32'd4094, 1'b0, 2);
      send_expect("beq_min", 5, 5'd0, 5'd3, 5'd4, -32'sd4096, 1'b0, 3);
      send_expect("jal_min", 6, 5'd31, 5'd0, 5'd0, -32'sd1048576, 1'b0, 4);
      send_expect("jal_max", 6, 5'd9, 5'd0, 5'd0, 32'd1048574, 1'b0, 5);
      send_expect("auipc", 9, 5'd10, 5'd0, 5'd0, 32'hFFFFF000, 1'b0, 6);
      send_expect("beq_odd", 5, 5'd0, 5'd1, 5'd2, 32'd3, 1'b1, 7);
      ref_encode(5, 5'd0, 5'd1, 5'd2, 32'd3, w, c);
      check("beq_odd_done", 64'(done), (c == 2'd0) ? 64'd1 : 64'd0);

      // ADDR_W=2 instance: four writes fit, the fifth descriptor overflows.
      do_start();
      base2 = dut2_writes;
      for (int i = 0; i < 5; i++) begin
         send(4'd2, 5'(i + 1), 5'd0, 5'd0, 32'(i), 1'b0);
         if (i == 3) begin
            ref_encode(2, 5'd4, 5'd0, 5'd0, 32'd3, w, c);
            check("ovf_last_addr", 64'(mem_wr_addr2), 64'd3);
            check("ovf_last_data", 64'(mem_wr_data2), 64'(w));
         end
      end
      #1;
      check("ovf_err", 64'(err2), 64'd1);
      check("ovf_code", 64'(err_code2), 64'd3);
      check("ovf_in_ready", 64'(in_ready2), 64'd0);
      check("ovf_busy", 64'(busy2), 64'd0);
      check("ovf_big_err", 64'(err), 64'd0);
      repeat (2) @(negedge clk);
      #1;
      check("ovf_nwrites", 64'(dut2_writes - base2), 64'd4);
      check("ovf_count", 64'(instr_count2), 64'd4);
      check("ovf_done", 64'(done2), 64'd0);

      // start while a write is stalled drops it.
      do_start();
      base = wr_q.size();
      send(4'd2, 5'd1, 5'd0, 5'd0, 32'd9, 1'b0);
      mem_wr_ready = 1'b0;
      #1;
      check("drop_pending_en", 64'(mem_wr_en), 64'd1);
      @(negedge clk);
      do_start();
      #1;
      check("drop_en", 64'(mem_wr_en), 64'd0);
      check("drop_count", 64'(instr_count), 64'd0);
      check("drop_busy", 64'(busy), 64'd1);
      mem_wr_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("drop_nwrites", 64'(wr_q.size() - base), 64'd0);

      // Randomized session with random backpressure, scored against the model.
      do_start();
      base = wr_q.size();
      rnd_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         int op;
         logic [4:0] rd, rs1, rs2;
         logic [31:0] imm;
         op  = int'($urandom_range(0, 9));
         rd  = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
         case (op)
            0, 1:       imm = $urandom;
            2, 3, 4, 7: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            5:          imm = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
            6:          imm = (32'($urandom_range(0, 1048575)) - 32'd524288) << 1;
            default:    imm = $urandom & 32'hFFFFF000;
         endcase
         ref_encode(op, rd, rs1, rs2, imm, w, c);
         exp_q.push_back('{AW'(i), w});
         send(4'(op), rd, rs1, rs2, imm, (i == 29));
      end
      begin
         bit seen = 1'b0;
         for (int k = 0; k < 200; k++) begin
            mem_wr_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (done) begin
               seen = 1'b1;
               break;
            end
            @(negedge clk);
         end
         check("rnd_done", 64'(seen), 64'd1);
      end
      @(negedge clk);
      rnd_ready = 1'b0;
      mem_wr_ready = 1'b1;
      #1;
      check("rnd_nwrites", 64'(wr_q.size() - base), 64'(exp_q.size()));
      check("rnd_count", 64'(instr_count), 64'd30);
      if (wr_q.size() - base == exp_q.size()) begin
         foreach (exp_q[i]) begin
            check("rnd_addr", 64'(wr_q[base + i].addr), 64'(exp_q[i].addr));
            check("rnd_data", 64'(wr_q[base + i].data), 64'(exp_q[i].data));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
